// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide over 32 cycles, sign fix-up, and a pipeline stall while busy.
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        fn_q, fn_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_out_q, rd_out_d;

    logic              is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    // Operand decode at capture: magnitudes plus the sign the final result must take.
    always_comb begin
        is_div   = func3[2];
        a_signed = is_div ? ~func3[0] : (func3[1:0] == 2'b01 || func3[1:0] == 2'b10);
        b_signed = is_div ? ~func3[0] : (func3[1:0] == 2'b01);
        sa       = a_signed & op_a[XLEN-1];
        sb       = b_signed & op_b[XLEN-1];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;
        div_zero = is_div && (op_b == '0);
        div_ovf  = is_div && !func3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (div_zero) special_res = func3[1] ? op_a : '1;
        else          special_res = func3[1] ? '0 : op_a;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix   = neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        fn_d     = fn_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        fn_d    = func3;
                        rd_d    = rd_in;
                        count_d = '0;
                        rem_d   = '0;
                        neg_d   = (is_div && func3[1]) ? sa : (sa ^ sb);
                        opnd_d  = is_div ? b_mag : a_mag;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
                        if (div_zero || div_ovf) begin
                            result_d = special_res;
                            rd_out_d = rd_in;
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // Divide keeps the dividend/quotient in the low half of acc.
                    if (fn_q[2]) begin
                        if (!div_diff[XLEN]) begin
                            rem_d = div_diff[XLEN-1:0];
                            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_d = div_shift[XLEN-1:0];
                            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(XLEN-1)) state_d = S_FIX;
                end
                S_FIX: begin
                    case (fn_q)
                        3'b000:                 result_d = prod_fix[XLEN-1:0];
                        3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
                        3'b100, 3'b101:         result_d = quo_fix;
                        default:                result_d = rem_fix;
                    endcase
                    rd_out_d = rd_q;
                    state_d  = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            fn_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            fn_q     <= fn_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Handshake: start is sampled only in IDLE; the upstream pipeline holds while
    // stall is high and the result is consumed on the edge that ends the done cycle.
    assign stall  = (state_q == S_IDLE && start && !kill) || state_q == S_CALC || state_q == S_FIX;
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized and directed bench for ex_muldiv_unit, checked against an
// arithmetic reference model of the RV32M operations and their timing.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset, start, kill;
    logic [2:0]  func3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res;
    logic [4:0]  last_rd;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .kill(kill), .func3(func3),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .stall(stall), .busy(busy),
        .done(done), .result(result), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, q;
        logic signed [63:0] sa64, sb64, ua64, ub64, p;
        logic               ovf;
        sa   = a;
        sb   = b;
        sa64 = sa;
        sb64 = sb;
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        ovf  = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua64 * ub64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                q = sa / sb;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                q = sa % sb;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 15);
            4:       return 32'hFFFF_FFFF - $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // One complete operation: counts stall cycles, checks done latency, result and rd.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int          stalls, dcyc, dones, exp_lat;
        logic [31:0] r;
        exp_q.push_back(ref_model(f, a, b));
        exp_lat = is_special(f, a, b) ? 1 : 34;
        @(posedge clk); #1;
        start = 1'b1; func3 = f; op_a = a; op_b = b; rd_in = rd;
        stalls = 0; dcyc = -1; dones = 0;
        @(negedge clk);
        if (stall) stalls++;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; func3 = 3'($urandom); rd_in = 5'($urandom);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin
                dones++;
                if (dcyc < 0) begin
                    dcyc = cyc;
                    r = exp_q.pop_front();
                    check($sformatf("result f%0d %h %h", f, a, b), result, r);
                    check("rd_out", {27'd0, rd_out}, {27'd0, rd});
                    last_res = r;
                    last_rd  = rd;
                end
            end
            if (dcyc > 0 && cyc == dcyc + 1) break;
            start = (cyc == 4 && exp_lat > 1);
        end
        start = 1'b0;
        if (dcyc < 0 && exp_q.size() > 0) void'(exp_q.pop_front());
        check("latency", dcyc, exp_lat);
        check("stall_cycles", stalls, exp_lat);
        check("done_pulses", dones, 1);
    endtask

    task automatic directed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [31:0] expv);
        run_op(f, a, b, rd);
        check($sformatf("directed f%0d", f), result, expv);
    endtask

    initial begin
        int          dones, d1, d2;
        logic [31:0] r1, r2;
        reset = 1'b1; start = 1'b0; kill = 1'b0; func3 = '0;
        op_a = '0; op_b = '0; rd_in = '0;
        last_res = '0; last_rd = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", {27'd0, rd_out}, 32'd0);
        check("rst_stall_lo", stall, 0);
        start = 1'b1; #1;
        check("rst_stall_hi", stall, 1);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        directed(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB);
        directed(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000);
        directed(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE);
        directed(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF);
        directed(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD);
        directed(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF);
        directed(3'd5, 32'd100,       32'd7,         5'd7,  32'd14);
        directed(3'd7, 32'd100,       32'd7,         5'd8,  32'd2);
        directed(3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF);
        directed(3'd6, 32'd5,         32'd0,         5'd10, 32'd5);
        directed(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        directed(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);

        // Randomized operations
        for (int i = 0; i < 80; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));

        // Kill at count=10: back to IDLE, no done, outputs held
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'd0; op_a = 32'd123; op_b = 32'd456; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_busy", busy, 0);
        check("kill_stall", stall, 0);
        check("kill_result", result, last_res);
        check("kill_rd_out", {27'd0, rd_out}, {27'd0, last_rd});
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("kill_no_done", dones, 0);
        run_op(3'd5, 32'd1000, 32'd33, 5'd18);

        // kill and start together in IDLE: nothing captured
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; func3 = 3'd0; op_a = 32'd3; op_b = 32'd4;
        @(negedge clk);
        check("killstart_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        @(negedge clk);
        check("killstart_busy", busy, 0);

        // Reset mid-CALC clears outputs immediately
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'd1; op_a = $urandom; op_b = $urandom; rd_in = 5'd21;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 32'd0);
        check("midrst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back MULs with start held high
        r1 = ref_model(3'd0, 32'd7, 32'hFFFF_FFFD);
        r2 = ref_model(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD; rd_in = 5'd25;
        @(posedge clk); #1;
        op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; rd_in = 5'd26;
        d1 = -1; d2 = -1;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    check("b2b_res1", result, r1);
                end else if (d2 < 0) begin
                    d2 = cyc;
                    check("b2b_res2", result, r2);
                    check("b2b_rd2", {27'd0, rd_out}, 32'd26);
                end
            end
            if (d2 > 0) break;
            @(posedge clk); #1;
            if (d1 > 0 && cyc == d1 + 1) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_first_lat", d1, 34);
        check("b2b_gap", d2 - d1, 35);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
